// File: rtl/mmio_store_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_store_fifo: memory-mapped TX FIFO with status/drop-count registers     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mmio_store_fifo #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        io_hit,
  output logic [31:0] io_ReadData,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        fifo_full
);

  localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);
  localparam logic [1:0]  SEL_TXDATA  = 2'd0;
  localparam logic [1:0]  SEL_STATUS  = 2'd1;
  localparam logic [1:0]  SEL_DROPCNT = 2'd2;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic [1:0]  sel;
  logic        empty, full;
  logic        push, pop, accept, drop, clr;
  logic [8:0]  count_ext;
  logic [31:0] status_word;

  assign io_hit = (Address[31:4] == IO_BASE[31:4]);
  assign sel    = Address[3:2];
  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_COUNT);
  assign push   = MemWrite & io_hit & (sel == SEL_TXDATA);
  assign pop    = !empty & out_ready;
  // A pop on the same edge frees a slot, so a push against a full FIFO still lands.
  assign accept = push & (!full | pop);
  assign drop   = push & full & !pop;
  assign clr    = MemWrite & io_hit & (sel == SEL_DROPCNT);

  assign count_ext   = 9'(count_q);
  assign status_word = {16'b0, count_ext[7:0], 6'b0, empty, full};

  always_comb begin
    mem_d = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q] = WriteData;
    end
    wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      drop_cnt_d = 8'd0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    io_ReadData = 32'b0;
    if (MemRead && io_hit) begin
      case (sel)
        SEL_STATUS:  io_ReadData = status_word;
        SEL_DROPCNT: io_ReadData = {24'b0, drop_cnt_q};
        default:     io_ReadData = 32'b0;
      endcase
    end
  end

  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign fifo_full = full;

  logic unused_bits;
  assign unused_bits = ^{Address[1:0], count_ext[8]};

endmodule
`default_nettype wire

// File: tb/tb_mmio_store_fifo.sv
`default_nettype none
// Self-checking bench for mmio_store_fifo: decode table, directed corners, random traffic vs queue model.
module tb_mmio_store_fifo;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData;
  logic        MemWrite, MemRead, out_ready;
  logic        io_hit, out_valid, fifo_full;
  logic [31:0] io_ReadData, out_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] q[$];
  int          drop_m = 0;

  mmio_store_fifo #(.IO_BASE(BASE), .DEPTH(DEPTH), .AW(3)) dut (
    .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .io_hit(io_hit), .io_ReadData(io_ReadData),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fifo_full(fifo_full)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: actual still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >> 4) == (BASE >> 4);
  endfunction

  function automatic logic [31:0] read_m();
    logic [1:0] s;
    s = Address[3:2];
    if (!(MemRead && in_window(Address))) return 32'h0;
    if (s == 2'd1) return {16'b0, 8'(q.size()), 6'b0, q.size() == 0, q.size() == DEPTH};
    if (s == 2'd2) return 32'(drop_m);
    return 32'h0;
  endfunction

  // One clock: check outputs against the model, then advance the model over the edge.
  task automatic cycle();
    bit push, pop, clr;
    logic [31:0] wd;
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    chk("io_hit", 32'(io_hit), 32'(in_window(Address)));
    chk("io_ReadData", io_ReadData, read_m());
    push = MemWrite && in_window(Address) && Address[3:2] == 2'd0;
    clr  = MemWrite && in_window(Address) && Address[3:2] == 2'd2;
    pop  = (q.size() != 0) && out_ready;
    wd   = WriteData;
    @(posedge clock);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(wd);
      else if (drop_m < 255) drop_m++;
    end
    if (clr) drop_m = 0;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
    cycle();
    MemWrite = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    Address = a; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
    d = io_ReadData;
    cycle();
    MemRead = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] d;
  logic [31:0] abc[3];
  logic [31:0] last;

  initial begin
    reset = 1'b1; Address = 32'h0; WriteData = 32'h0;
    MemWrite = 1'b0; MemRead = 1'b0; out_ready = 1'b0;

    vecs[0] = '{BASE + 32'h4,  1'b1, 1'b1, 32'h0000_0002};
    vecs[1] = '{BASE + 32'h7,  1'b1, 1'b1, 32'h0000_0002};
    vecs[2] = '{BASE + 32'h0,  1'b1, 1'b1, 32'h0};
    vecs[3] = '{BASE + 32'h8,  1'b1, 1'b1, 32'h0};
    vecs[4] = '{BASE + 32'hC,  1'b1, 1'b1, 32'h0};
    vecs[5] = '{BASE + 32'h10, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_0004, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{BASE + 32'h4,  1'b0, 1'b1, 32'h0};
    vecs[8] = '{32'hFFFF_000F, 1'b1, 1'b1, 32'h0};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_full", 32'(fifo_full), 32'h0);
    chk("reset_data", out_data, 32'h0);
    read_reg(BASE + 32'h4, d);
    chk("reset_status", d, 32'h0000_0002);

    // Decode table on an idle FIFO
    for (int i = 0; i < 9; i++) begin
      Address = vecs[i].addr; MemRead = vecs[i].rd; MemWrite = 1'b0;
      #1;
      chk("vec_hit", 32'(io_hit), 32'(vecs[i].exp_hit));
      chk("vec_rdata", io_ReadData, vecs[i].exp_data);
      cycle();
    end
    MemRead = 1'b0;

    // Order and latency
    abc[0] = 32'hA; abc[1] = 32'hB; abc[2] = 32'hC;
    for (int i = 0; i < 3; i++) store(BASE, abc[i]);
    read_reg(BASE + 32'h4, d);
    chk("status_cnt3", d, 32'h0000_0300);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_abc", out_data, abc[i]);
      cycle();
    end
    chk("abc_empty", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Overflow by one
    for (int i = 1; i <= 9; i++) store(BASE, 32'(i));
    chk("ovf_full", 32'(fifo_full), 32'h1);
    read_reg(BASE + 32'h8, d);
    chk("ovf_dropcnt", d, 32'h1);
    read_reg(BASE + 32'h4, d);
    chk("ovf_status", d, 32'h0000_0801);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain", out_data, 32'(i));
      cycle();
    end
    chk("ovf_empty", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Push and pop together while full
    store(BASE + 32'h8, 32'h0);
    for (int i = 1; i <= 8; i++) store(BASE, 32'(i));
    out_ready = 1'b1;
    store(BASE, 32'h55);
    out_ready = 1'b0;
    read_reg(BASE + 32'h8, d);
    chk("pp_nodrop", d, 32'h0);
    read_reg(BASE + 32'h4, d);
    chk("pp_status", d, 32'h0000_0801);
    out_ready = 1'b1;
    last = 32'h0;
    for (int i = 0; i < 8; i++) begin
      last = out_data;
      cycle();
    end
    chk("pp_last", last, 32'h55);
    chk("pp_empty", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Backpressure hold, then interleaved traffic across the wrap
    store(BASE, 32'h77);
    for (int i = 0; i < 5; i++) begin
      chk("hold_77", out_data, 32'h77);
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      Address = BASE; WriteData = $urandom; MemWrite = 1'($urandom_range(0, 1));
      cycle();
    end
    MemWrite = 1'b0;

    // Broader random traffic over the whole window and outside it
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      out_ready = ($urandom_range(0, 3) == 0);
      WriteData = $urandom;
      MemRead = 1'($urandom_range(0, 1));
      MemWrite = 1'b0;
      case (r)
        0, 1, 2, 3, 4: begin Address = BASE | 32'($urandom_range(0, 3)); MemWrite = 1'b1; end
        5: Address = BASE + 32'h4 + 32'($urandom_range(0, 3));
        6: begin Address = BASE + 32'h8; MemWrite = ($urandom_range(0, 3) == 0); end
        7: begin Address = BASE + 32'hC; MemWrite = 1'b1; end
        8: begin Address = BASE + 32'h4; MemWrite = 1'b1; end
        default: begin Address = BASE + 32'h10; MemWrite = 1'b1; end
      endcase
      cycle();
    end
    MemWrite = 1'b0; MemRead = 1'b0; out_ready = 1'b0;

    // Saturation, clear, then asynchronous reset with words queued
    store(BASE + 32'h8, 32'h0);
    while (q.size() < DEPTH) store(BASE, $urandom);
    for (int i = 0; i < 300; i++) store(BASE, $urandom);
    read_reg(BASE + 32'h8, d);
    chk("sat_dropcnt", d, 32'd255);
    store(BASE + 32'h8, 32'hDEAD_BEEF);
    read_reg(BASE + 32'h8, d);
    chk("clr_dropcnt", d, 32'h0);
    out_ready = 1'b1;
    repeat (4) cycle();
    out_ready = 1'b0;
    read_reg(BASE + 32'h4, d);
    chk("pre_rst_status", d, 32'h0000_0400);
    Address = BASE + 32'h4; MemRead = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", out_data, 32'h0);
    chk("arst_status", io_ReadData, 32'h0000_0002);
    #1;
    reset = 1'b0;
    q.delete();
    drop_m = 0;
    @(posedge clock);
    #1;
    repeat (3) cycle();
    MemRead = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
